// File: rtl/pdc_update_ctrl.sv
// pdc_update_ctrl: queues resolved EX branch records, flags mispredicts, and drives the predictor write port.
// Sweep-clears the predictor tables after reset. Optional perf counters are enabled by `PDC_PERF_CNT_EN. Rev 1.0
`default_nettype none

module pdc_update_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid_0,
  input  logic             in_valid_1,
  input  logic             in_taken_pdc_0,
  input  logic             in_taken_pdc_1,
  input  logic [2:0]       in_kind_pdc_0,
  input  logic [2:0]       in_kind_pdc_1,
  input  logic [29:0]      in_npc_pdc_0,
  input  logic [29:0]      in_npc_pdc_1,
  input  logic             in_taken_ex_0,
  input  logic             in_taken_ex_1,
  input  logic [2:0]       in_kind_ex_0,
  input  logic [2:0]       in_kind_ex_1,
  input  logic [29:0]      in_npc_ex_0,
  input  logic [29:0]      in_npc_ex_1,
  input  logic [29:0]      in_pc_ex_0,
  input  logic [29:0]      in_pc_ex_1,
  output logic             in_ready,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [29:0]      upd_pc,
  output logic [29:0]      upd_npc,
  output logic [2:0]       upd_kind,
  output logic             upd_taken,
  output logic             upd_mispred,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx,
  output logic             init_done
`ifdef PDC_PERF_CNT_EN
  ,
  output logic [31:0]      perf_upd_cnt,
  output logic [31:0]      perf_mispred_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] pc;
    logic [29:0] npc;
    logic [2:0]  kind;
    logic        taken;
    logic        mispred;
  } rec_t;

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] clr_cnt;
  logic             run, clearing;
  rec_t             mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ready_int, valid_int, push0, push1, pop;
  rec_t             rec0, rec1, head;

  function automatic logic mispred_f(input logic tp, input logic [2:0] kp, input logic [29:0] np,
                                     input logic te, input logic [2:0] ke, input logic [29:0] ne);
    return (tp != te) | (kp != ke) | (te & (np != ne));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    run      = 1'b0;
    clearing = 1'b0;
    case (state)
      S_INIT: begin
        clearing = 1'b1;
        if (clr_cnt == '1) state_nx = S_RUN;
      end
      S_RUN:   run = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + 1'b1;
  end

  // Ready uses the registered count only; a same-cycle pop never frees a slot early.
  assign ready_int = run && (count <= CW'(DEPTH - 2));
  assign valid_int = run && (count != '0);
  assign push0     = ready_int && !flush && in_valid_0 && (in_kind_ex_0 != 3'd0);
  assign push1     = ready_int && !flush && in_valid_1 && (in_kind_ex_1 != 3'd0);
  assign pop       = valid_int && upd_ready;

  assign rec0 = '{pc: in_pc_ex_0, npc: in_npc_ex_0, kind: in_kind_ex_0, taken: in_taken_ex_0,
                  mispred: mispred_f(in_taken_pdc_0, in_kind_pdc_0, in_npc_pdc_0,
                                     in_taken_ex_0, in_kind_ex_0, in_npc_ex_0)};
  assign rec1 = '{pc: in_pc_ex_1, npc: in_npc_ex_1, kind: in_kind_ex_1, taken: in_taken_ex_1,
                  mispred: mispred_f(in_taken_pdc_1, in_kind_pdc_1, in_npc_pdc_1,
                                     in_taken_ex_1, in_kind_ex_1, in_npc_ex_1)};

  // Slot1 lands directly behind slot0 when both push, otherwise at the write pointer.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= rec0;
    if (push1) mem[wr_ptr + PW'(push0)] <= rec1;
  end

  always_ff @(posedge clk) begin
    if (rst || (run && flush)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  assign in_ready    = !rst && ready_int;
  assign upd_valid   = !rst && valid_int;
  assign upd_pc      = upd_valid ? head.pc      : '0;
  assign upd_npc     = upd_valid ? head.npc     : '0;
  assign upd_kind    = upd_valid ? head.kind    : '0;
  assign upd_taken   = upd_valid && head.taken;
  assign upd_mispred = upd_valid && head.mispred;
  assign clr_en      = !rst && clearing;
  assign clr_idx     = rst ? '0 : clr_cnt;
  assign init_done   = !rst && run;

`ifdef PDC_PERF_CNT_EN
  logic [31:0] upd_cnt, mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_cnt     <= '0;
      mispred_cnt <= '0;
    end else if (pop) begin
      upd_cnt     <= upd_cnt + 32'd1;
      mispred_cnt <= mispred_cnt + 32'(head.mispred);
    end
  end

  assign perf_upd_cnt     = rst ? '0 : upd_cnt;
  assign perf_mispred_cnt = rst ? '0 : mispred_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pdc_update_ctrl.sv
// tb_pdc_update_ctrl: randomized stimulus against a queue-based reference model of pdc_update_ctrl.
`default_nettype none

module tb_pdc_update_ctrl;
  localparam int DEPTH = 8;
  localparam int IDX_W = 4;
  localparam int NCLR  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic upd_ready = 1'b0;
  logic        valid    [2];
  logic        taken_pdc[2];
  logic [2:0]  kind_pdc [2];
  logic [29:0] npc_pdc  [2];
  logic        taken_ex [2];
  logic [2:0]  kind_ex  [2];
  logic [29:0] npc_ex   [2];
  logic [29:0] pc_ex    [2];

  logic             in_ready, upd_valid, upd_taken, upd_mispred, clr_en, init_done;
  logic [29:0]      upd_pc, upd_npc;
  logic [2:0]       upd_kind;
  logic [IDX_W-1:0] clr_idx;
`ifdef PDC_PERF_CNT_EN
  logic [31:0] perf_upd_cnt, perf_mispred_cnt;
`endif

  always #5 clk = ~clk;

  pdc_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_0(valid[0]), .in_valid_1(valid[1]),
    .in_taken_pdc_0(taken_pdc[0]), .in_taken_pdc_1(taken_pdc[1]),
    .in_kind_pdc_0(kind_pdc[0]), .in_kind_pdc_1(kind_pdc[1]),
    .in_npc_pdc_0(npc_pdc[0]), .in_npc_pdc_1(npc_pdc[1]),
    .in_taken_ex_0(taken_ex[0]), .in_taken_ex_1(taken_ex[1]),
    .in_kind_ex_0(kind_ex[0]), .in_kind_ex_1(kind_ex[1]),
    .in_npc_ex_0(npc_ex[0]), .in_npc_ex_1(npc_ex[1]),
    .in_pc_ex_0(pc_ex[0]), .in_pc_ex_1(pc_ex[1]),
    .in_ready(in_ready), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_npc(upd_npc), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .clr_en(clr_en), .clr_idx(clr_idx), .init_done(init_done)
`ifdef PDC_PERF_CNT_EN
    , .perf_upd_cnt(perf_upd_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  typedef struct {
    logic [29:0] pc;
    logic [29:0] npc;
    logic [2:0]  kind;
    logic        taken;
    logic        mispred;
  } rec_t;

  rec_t        q[$];
  int          cycles_since_rst = 0;
  logic [31:0] m_upd = 0, m_mis = 0;
  int          n_cmp = 0, n_err = 0;
  int          ready_pct = 50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return cycles_since_rst >= NCLR;
  endfunction

  task automatic check_outputs();
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_upd_valid", 64'(upd_valid), 0);
      chk("rst_clr_en", 64'(clr_en), 0);
      chk("rst_clr_idx", 64'(clr_idx), 0);
      chk("rst_init_done", 64'(init_done), 0);
      chk("rst_upd_fields", 64'({upd_pc, upd_kind, upd_taken, upd_mispred}), 0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(m_run() && q.size() <= DEPTH - 2));
      chk("upd_valid", 64'(upd_valid), 64'(m_run() && q.size() != 0));
      chk("clr_en", 64'(clr_en), 64'(!m_run()));
      chk("init_done", 64'(init_done), 64'(m_run()));
      if (!m_run()) chk("clr_idx", 64'(clr_idx), 64'(cycles_since_rst));
      if (m_run() && q.size() != 0) begin
        chk("upd_pc", 64'(upd_pc), 64'(q[0].pc));
        chk("upd_npc", 64'(upd_npc), 64'(q[0].npc));
        chk("upd_kind", 64'(upd_kind), 64'(q[0].kind));
        chk("upd_taken", 64'(upd_taken), 64'(q[0].taken));
        chk("upd_mispred", 64'(upd_mispred), 64'(q[0].mispred));
      end
    end
`ifdef PDC_PERF_CNT_EN
    chk("perf_upd_cnt", 64'(perf_upd_cnt), rst ? 64'd0 : 64'(m_upd));
    chk("perf_mispred_cnt", 64'(perf_mispred_cnt), rst ? 64'd0 : 64'(m_mis));
`endif
  endtask

  // Predicted fields: exact match, not-taken with stale target, target-only miss, or unrelated.
  task automatic gen_slot(input int s);
    int mode;
    valid[s]    = ($urandom_range(0, 3) != 0);
    kind_ex[s]  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
    taken_ex[s] = 1'($urandom);
    npc_ex[s]   = 30'($urandom);
    pc_ex[s]    = 30'($urandom);
    mode = $urandom_range(0, 3);
    taken_pdc[s] = taken_ex[s];
    kind_pdc[s]  = kind_ex[s];
    npc_pdc[s]   = npc_ex[s];
    case (mode)
      1: begin taken_ex[s] = 1'b0; taken_pdc[s] = 1'b0; npc_pdc[s] = npc_ex[s] ^ 30'h4; end
      2: begin taken_ex[s] = 1'b1; taken_pdc[s] = 1'b1; npc_pdc[s] = npc_ex[s] + 30'd1; end
      3: begin taken_pdc[s] = 1'($urandom); kind_pdc[s] = 3'($urandom); npc_pdc[s] = 30'($urandom); end
      default: ;
    endcase
  endtask

  task automatic step(input logic rst_val);
    bit   acc, pop;
    rec_t r;
    @(negedge clk);
    check_outputs();
    rst       = rst_val;
    flush     = ($urandom_range(0, 99) < 3);
    upd_ready = ($urandom_range(0, 99) < ready_pct);
    gen_slot(0);
    gen_slot(1);
    acc = m_run() && q.size() <= DEPTH - 2;
    pop = m_run() && q.size() != 0 && upd_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cycles_since_rst = 0;
      m_upd = 0;
      m_mis = 0;
    end else if (!m_run()) begin
      cycles_since_rst++;
    end else begin
      if (pop) begin
        m_upd++;
        if (q[0].mispred) m_mis++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc) begin
        for (int s = 0; s < 2; s++) begin
          if (valid[s] && kind_ex[s] != 3'd0) begin
            r.pc = pc_ex[s]; r.npc = npc_ex[s]; r.kind = kind_ex[s]; r.taken = taken_ex[s];
            r.mispred = (taken_pdc[s] != taken_ex[s]) || (kind_pdc[s] != kind_ex[s]) ||
                        (taken_ex[s] && npc_pdc[s] != npc_ex[s]);
            q.push_back(r);
          end
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      valid[s] = 0; taken_pdc[s] = 0; kind_pdc[s] = 0; npc_pdc[s] = 0;
      taken_ex[s] = 0; kind_ex[s] = 0; npc_ex[s] = 0; pc_ex[s] = 0;
    end
    repeat (3) step(1'b1);
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) ready_pct = (i / 100 % 3 == 0) ? 10 : (i / 100 % 3 == 1) ? 50 : 90;
      step(1'b0);
    end
    repeat (2) step(1'b1);
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) ready_pct = (i / 100 % 2 == 0) ? 20 : 80;
      step(1'b0);
    end
    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
